mem_cmd_queue: RTL
==================

// Module: mem_cmd_queue
// PURPOSE
//  Request front-end feeding memory_controller. Buffers user read/write requests in a DEPTH-entry FIFO.
//  Issues requests one at a time on the controller's cmd/addr/dq/ready interface, then waits for valid.
//  Returns one response per request: read data, or a timeout error if valid never arrives.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of 2, >=2
//  ADDR_W   25  request/controller address width
//  DATA_W   16  data width
//  TIMEOUT  64  max cycles in WAIT before error response; >=2
// PORTS
//  clk        in   1       system clock, 50 MHz, rising edge
//  rst        in   1       asynchronous active-low reset (0 = reset)
//  req_valid  in   1       user request present
//  req_ready  out  1       queue can accept (= !full, registered)
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       1-cycle response pulse
//  rsp_we     out  1       type of the completed request
//  rsp_err    out  1       1 = request timed out
//  rsp_rdata  out  DATA_W  read data; 0 for writes/errors
//  q_count    out  $clog2(DEPTH)+1  entries currently queued
//  mc_cmd     out  2       one-hot: 2'b10 write, 2'b01 read, 2'b00 idle
//  mc_addr    out  ADDR_W  to controller addr
//  mc_ready   out  1       1-cycle command strobe to controller ready
//  mc_valid   in   1       controller completion flag
//  mc_dq_o    out  DATA_W  write data toward controller dq
//  mc_dq_oe   out  1       1 = drive dq (writes, ISSUE+WAIT); top level builds tri-state
//  mc_dq_i    in   DATA_W  read data from controller dq
// BEHAVIOUR
//  Reset (rst=0, async): FIFO emptied, FSM=IDLE, timeout counter=0. Outputs: req_ready=1, rsp_*=0,
//   q_count=0, mc_cmd=2'b00, mc_addr=0, mc_ready=0, mc_dq_o=0, mc_dq_oe=0. Reset mid-transaction
//   abandons it, no response. Same-cycle push is dropped.
//  FIFO: push on req_valid&&req_ready; pop on IDLE->ISSUE. Pointers wrap mod DEPTH.
//   Same-cycle push+pop: count unchanged. Full: req_ready=0; no push, even if pop same cycle.
//  FSM IDLE: mc_cmd=00, oe=0. If count!=0: pop head into issue regs -> ISSUE.
//  FSM ISSUE (exactly 1 cycle): mc_ready=1, mc_cmd/mc_addr/mc_dq_o from issue regs; oe=we -> WAIT.
//  FSM WAIT: mc_ready=0; cmd/addr/dq_o/oe held stable; counter increments each cycle.
//   mc_valid=1 -> capture mc_dq_i if read, err=0 -> RESP.
//   Else counter==TIMEOUT-1 -> err=1, rdata=0 -> RESP. mc_valid on that same cycle wins (no error).
//  FSM RESP (1 cycle): rsp_valid=1 with rsp_we/err/rdata; mc_cmd=00, oe=0; counter=0 -> IDLE.
//  mc_valid outside WAIT ignored. rsp_* hold last values when rsp_valid=0.
//  Latency: push at edge N into empty queue+IDLE -> mc_ready high in cycle after edge N+1;
//   rsp_valid 1 cycle after the edge sampling mc_valid. Min 4 cycles/request; one outstanding.
//  Strict FIFO order. q_count excludes the request in flight.
// TESTING
//  1 Reset: hold rst=0, push attempt -> all outputs at reset values, q_count=0, no response.
//  2 Write 0x0FFFF/0xAAAA, mc_valid after 3 cycles -> ISSUE: mc_cmd=10, mc_dq_o=AAAA, oe=1, 1 ready pulse;
//    rsp_valid, rsp_we=1, err=0.
//  3 Read 0x0FFFF, mc_dq_i=0xAAAA with mc_valid -> mc_cmd=01, oe=0; rsp_rdata=AAAA, rsp_we=0.
//  4 Push 5 with mc_valid held low (DEPTH=4) -> 4 accepted, req_ready=0, 5th dropped; responses in order.
//  5 No mc_valid -> rsp_err=1 exactly TIMEOUT cycles after ISSUE; next request issues normally.
//  6 rst=0 mid-WAIT -> mc_cmd=00, queue empty, no rsp_valid; mc_valid during IDLE causes nothing.

Source files
------------

// File: rtl/mem_cmd_queue.sv
// -----------------------------------------------------------------------------
// mem_cmd_queue
//
// Request front-end for memory_controller. User read/write requests are
// buffered in a DEPTH-entry FIFO and issued one at a time on the controller's
// cmd/addr/dq/ready interface. After each command the block waits for the
// controller's valid flag. It then returns exactly one response per request:
// read data, or an error if valid does not arrive within TIMEOUT cycles.
//
// Handshake semantics:
//   req_valid/req_ready : a request is taken on a rising edge where both are 1.
//                         req_ready is registered (= !full) and may fall
//                         only after the edge that fills the queue.
//   mc_ready            : one-cycle command strobe. The command stays stable
//                         until the response cycle.
//   mc_valid            : sampled only while waiting. It is ignored at all
//                         other times.
//   rsp_valid           : one-cycle pulse with no back-pressure.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req_valid/ready     user request handshake
//   req_we/addr/wdata   request type, address and write data
//   rsp_valid/we/err    response strobe, request type and timeout flag
//   rsp_rdata           read data (0 for writes and errors)
//   q_count             queued entries, excluding the one in flight
//   mc_cmd/addr/ready   command toward the controller
//   mc_valid, mc_dq_i   completion flag and read data from the controller
//   mc_dq_o, mc_dq_oe   write data and its output enable
//   fsm_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module mem_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_we,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [1:0]               mc_cmd,
    output logic [ADDR_W-1:0]        mc_addr,
    output logic                     mc_ready,
    input  logic                     mc_valid,
    output logic [DATA_W-1:0]        mc_dq_o,
    output logic                     mc_dq_oe,
    input  logic [DATA_W-1:0]        mc_dq_i,
    output logic [1:0]               fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO storage. The entries need no reset because the pointers and count
    // decide which entries are valid.
    logic              fifo_we    [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;

    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;

    logic [TW-1:0] wait_cnt;
    logic          push, pop, wait_done;

    // A full queue keeps req_ready low, so a pop in the same cycle cannot
    // make room for a push until the next cycle.
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign wait_done = (state == S_WAIT) && (mc_valid || (wait_cnt == TO_LAST));

    always_comb begin
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= req_we;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            req_ready <= (count_nxt != FULL_CNT);
        end
    end

    // Issue registers hold the in-flight request from ISSUE through RESP.
    // Write data is zeroed for reads so dq_o never shows stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end else if (pop) begin
            iss_we    <= fifo_we[rd_ptr];
            iss_addr  <= fifo_addr[rd_ptr];
            iss_wdata <= fifo_we[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // A completion in the final wait cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (wait_done) begin
            rsp_we    <= iss_we;
            rsp_err   <= !mc_valid;
            rsp_rdata <= (mc_valid && !iss_we) ? mc_dq_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mc_cmd    = 2'b00;
        mc_ready  = 1'b0;
        mc_dq_oe  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mc_ready  = 1'b1;
                mc_cmd    = iss_we ? 2'b10 : 2'b01;
                mc_dq_oe  = iss_we;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mc_cmd   = iss_we ? 2'b10 : 2'b01;
                mc_dq_oe = iss_we;
                if (wait_done) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mc_addr   = iss_addr;
    assign mc_dq_o   = iss_wdata;
    assign q_count   = count;
    assign fsm_state = state;

endmodule
